// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and default widths for the unified-memory arbiter slice.
//   state_t : arbiter sequencer states (IDLE, ACCESS, WAIT, RESP)
//   owner_t : which requester owns the access in flight (OWN_I fetch, OWN_D data)
//   ADDR_W_DEF / DATA_W_DEF : default word-address and data widths
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 30;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_perf.sv
// -----------------------------------------------------------------------------
// mem_arb_perf
// Free-running, wrapping 32-bit performance counters for mem_arbiter.
// Instantiated only when MEM_ARB_PERF_EN is defined.
// Ports:
//   clk, rst       : clock, synchronous active-high reset (clears all counters)
//   i_req          : fetch request from the core
//   i_gnt, d_gnt   : grants issued by the arbiter this cycle
//   perf_i_grants  : number of fetch grants
//   perf_d_grants  : number of data grants
//   perf_i_stall   : cycles with a fetch request pending but not granted
// -----------------------------------------------------------------------------
module mem_arb_perf (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic        i_gnt,
    input  logic        d_gnt,
    output logic [31:0] perf_i_grants,
    output logic [31:0] perf_d_grants,
    output logic [31:0] perf_i_stall
);

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_i_grants <= '0;
            perf_d_grants <= '0;
            perf_i_stall  <= '0;
        end else begin
            if (i_gnt)
                perf_i_grants <= perf_i_grants + 32'd1;
            if (d_gnt)
                perf_d_grants <= perf_d_grants + 32'd1;
            if (i_req && !i_gnt)
                perf_i_stall <= perf_i_stall + 32'd1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Two-requester arbiter/sequencer for the single-port unified instruction/data
// memory. Fetch and load/store requests are serialised onto one memory port,
// one access in flight at a time: grant (IDLE) -> ACCESS -> WAIT x (RD_LAT-1)
// -> RESP. Data wins arbitration unless fetch has been passed over
// STARVE_LIMIT times in a row.
//
// Optional feature: define MEM_ARB_PERF_EN to add perf_i_grants,
// perf_d_grants and perf_i_stall outputs (32-bit wrapping counters).
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   i_req, i_addr            : fetch request / word address (held until i_gnt)
//   i_gnt                    : fetch accepted this cycle (combinational)
//   i_rsp_valid, i_rdata     : fetch response pulse and data
//   d_req, d_we, d_addr,
//   d_wdata                  : data request (we=1 store), held until d_gnt
//   d_gnt                    : data request accepted this cycle (combinational)
//   d_rsp_valid, d_rdata     : load data / store-complete pulse
//   mem_addr, mem_wdata,
//   mem_wren, mem_rren,
//   mem_en                   : memory port controls, non-zero only in ACCESS
//   mem_rdata                : memory read data, valid RD_LAT cycles after ACCESS
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int RD_LAT       = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rsp_valid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rsp_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wren,
    output logic              mem_rren,
    output logic              mem_en,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_i_grants,
    output logic [31:0]       perf_d_grants,
    output logic [31:0]       perf_i_stall
`endif
);

    // WAIT lasts RD_LAT-1 cycles: the counter is loaded with RD_LAT-2 and
    // RESP is entered when it reaches zero.
    localparam int              CNT_W      = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0] WAIT_INIT = (RD_LAT >= 2) ? CNT_W'(RD_LAT - 2) : '0;
    localparam logic [2:0]      STARVE_LIM = 3'(STARVE_LIMIT);

    state_t            state;
    owner_t            owner;
    logic [ADDR_W-1:0] lat_addr;
    logic              lat_we;
    logic [DATA_W-1:0] lat_wdata;
    logic [CNT_W-1:0]  wait_cnt;
    logic [2:0]        starve_cnt;

    logic idle_ok;
    logic access_ok;
    logic resp_ok;
    logic fetch_wins;

    // Outputs are forced to zero while rst is high so that a reset landing in
    // any state (including an aborted ACCESS/RESP) shows no grant or pulse.
    assign idle_ok   = (state == IDLE)   && !rst;
    assign access_ok = (state == ACCESS) && !rst;
    assign resp_ok   = (state == RESP)   && !rst;

    // A lone requester always wins; with both pending, fetch wins only once
    // it has been passed over STARVE_LIMIT times.
    assign fetch_wins = i_req && (!d_req || (starve_cnt == STARVE_LIM));

    assign i_gnt = idle_ok && fetch_wins;
    assign d_gnt = idle_ok && d_req && !fetch_wins;

    assign mem_en    = access_ok;
    assign mem_wren  = access_ok && lat_we;
    assign mem_rren  = access_ok && !lat_we;
    assign mem_addr  = access_ok ? lat_addr  : '0;
    assign mem_wdata = access_ok ? lat_wdata : '0;

    assign i_rsp_valid = resp_ok && (owner == OWN_I);
    assign d_rsp_valid = resp_ok && (owner == OWN_D);
    assign i_rdata     = i_rsp_valid ? mem_rdata : '0;
    assign d_rdata     = d_rsp_valid ? mem_rdata : '0;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the request latches are reset as well so mem_* never
            // carries stale data from a previous run, even in simulation.
            state      <= IDLE;
            owner      <= OWN_I;
            lat_addr   <= '0;
            lat_we     <= 1'b0;
            lat_wdata  <= '0;
            wait_cnt   <= '0;
            starve_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!i_req || i_gnt)
                        starve_cnt <= '0;
                    else if (d_gnt && (starve_cnt != 3'd7))
                        starve_cnt <= starve_cnt + 3'd1;

                    if (i_gnt) begin
                        owner     <= OWN_I;
                        lat_addr  <= i_addr;
                        lat_we    <= 1'b0;
                        lat_wdata <= '0;
                        state     <= ACCESS;
                    end else if (d_gnt) begin
                        owner     <= OWN_D;
                        lat_addr  <= d_addr;
                        lat_we    <= d_we;
                        lat_wdata <= d_wdata;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (RD_LAT == 1) begin
                        state <= RESP;
                    end else begin
                        wait_cnt <= WAIT_INIT;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == '0)
                        state <= RESP;
                    else
                        wait_cnt <= wait_cnt - 1'b1;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef MEM_ARB_PERF_EN
    mem_arb_perf u_perf (
        .clk           (clk),
        .rst           (rst),
        .i_req         (i_req),
        .i_gnt         (i_gnt),
        .d_gnt         (d_gnt),
        .perf_i_grants (perf_i_grants),
        .perf_d_grants (perf_d_grants),
        .perf_i_stall  (perf_i_stall)
    );
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter. Two instances share clk/rst: u_dut with
// RD_LAT=1 and u_dut3 with RD_LAT=3, each with its own behavioural memory.
// Inputs change 1 time unit after posedge; outputs are sampled at negedge.
// Build with MEM_ARB_PERF_EN defined to also exercise the perf counters.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 30;
    localparam int DW = 32;

    logic          clk;
    logic          rst;

    // RD_LAT = 1 instance
    logic          i_req, i_gnt, i_rsp_valid;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          d_req, d_we, d_gnt, d_rsp_valid;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_wren, mem_rren, mem_en;
`ifdef MEM_ARB_PERF_EN
    logic [31:0]   perf_i_grants, perf_d_grants, perf_i_stall;
    logic [31:0]   l3_perf_i_grants, l3_perf_d_grants, l3_perf_i_stall;
`endif

    // RD_LAT = 3 instance
    logic          l3_i_req, l3_i_gnt, l3_i_rsp_valid;
    logic [AW-1:0] l3_i_addr;
    logic [DW-1:0] l3_i_rdata;
    logic          l3_d_req, l3_d_we, l3_d_gnt, l3_d_rsp_valid;
    logic [AW-1:0] l3_d_addr;
    logic [DW-1:0] l3_d_wdata, l3_d_rdata;
    logic [AW-1:0] l3_mem_addr;
    logic [DW-1:0] l3_mem_wdata, l3_mem_rdata;
    logic          l3_mem_wren, l3_mem_rren, l3_mem_en;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .STARVE_LIMIT(4)) u_dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
        .i_rsp_valid(i_rsp_valid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rsp_valid(d_rsp_valid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
        .mem_rren(mem_rren), .mem_en(mem_en), .mem_rdata(mem_rdata)
`ifdef MEM_ARB_PERF_EN
        , .perf_i_grants(perf_i_grants), .perf_d_grants(perf_d_grants),
        .perf_i_stall(perf_i_stall)
`endif
    );

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3), .STARVE_LIMIT(4)) u_dut3 (
        .clk(clk), .rst(rst),
        .i_req(l3_i_req), .i_addr(l3_i_addr), .i_gnt(l3_i_gnt),
        .i_rsp_valid(l3_i_rsp_valid), .i_rdata(l3_i_rdata),
        .d_req(l3_d_req), .d_we(l3_d_we), .d_addr(l3_d_addr), .d_wdata(l3_d_wdata),
        .d_gnt(l3_d_gnt), .d_rsp_valid(l3_d_rsp_valid), .d_rdata(l3_d_rdata),
        .mem_addr(l3_mem_addr), .mem_wdata(l3_mem_wdata), .mem_wren(l3_mem_wren),
        .mem_rren(l3_mem_rren), .mem_en(l3_mem_en), .mem_rdata(l3_mem_rdata)
`ifdef MEM_ARB_PERF_EN
        , .perf_i_grants(l3_perf_i_grants), .perf_d_grants(l3_perf_d_grants),
        .perf_i_stall(l3_perf_i_stall)
`endif
    );

    // Behavioural memories: write on the ACCESS edge; read data appears
    // RD_LAT cycles after the ACCESS edge and is held until the next read.
    logic [DW-1:0] mem  [0:4095];
    logic [DW-1:0] mem3 [0:4095];
    logic [DW-1:0] rd_q;
    logic [DW-1:0] rd3_s0, rd3_s1, rd3_s2;

    always @(posedge clk) begin
        if (mem_en && mem_wren)
            mem[mem_addr[11:0]] <= mem_wdata;
        if (mem_en && mem_rren)
            rd_q <= mem[mem_addr[11:0]];
    end
    assign mem_rdata = rd_q;

    always @(posedge clk) begin
        if (l3_mem_en && l3_mem_wren)
            mem3[l3_mem_addr[11:0]] <= l3_mem_wdata;
        if (l3_mem_en && l3_mem_rren)
            rd3_s0 <= mem3[l3_mem_addr[11:0]];
        rd3_s1 <= rd3_s0;
        rd3_s2 <= rd3_s1;
    end
    assign l3_mem_rdata = rd3_s2;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic mid;
        @(negedge clk);
    endtask

    // ---------------------------------------------------------------- reset
    task automatic test_reset;
        rst = 1'b1;
        i_req = 1'b1; i_addr = '0;
        nxt;
        mid;
        n_checks++;
        if ({i_gnt, d_gnt, i_rsp_valid, d_rsp_valid, mem_en, mem_wren, mem_rren} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctl got=%b exp=0000000",
                     {i_gnt, d_gnt, i_rsp_valid, d_rsp_valid, mem_en, mem_wren, mem_rren});
        end
        n_checks++;
        if ({mem_addr, mem_wdata, i_rdata, d_rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_data got addr=%0h wdata=%0h irdata=%0h drdata=%0h exp=0",
                     mem_addr, mem_wdata, i_rdata, d_rdata);
        end
    endtask

    // ---------------------------------------------------------------- fetch
    task automatic test_fetch;
        nxt;
        rst = 1'b0;
        mid;
        n_checks++;
        if (i_gnt !== 1'b1 || d_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_gnt got i_gnt=%b d_gnt=%b exp i_gnt=1 d_gnt=0", i_gnt, d_gnt);
        end
        nxt;
        i_req = 1'b0;
        mid;
        n_checks++;
        if ({mem_en, mem_rren, mem_wren} !== 3'b110 || mem_addr !== '0) begin
            n_fail++;
            $display("FAIL fetch_access got en/rren/wren=%b addr=%0h exp 110 addr=0",
                     {mem_en, mem_rren, mem_wren}, mem_addr);
        end
        nxt;
        mid;
        n_checks++;
        if (i_rsp_valid !== 1'b1 || i_rdata !== 32'h2008_2000 || d_rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_resp got ivld=%b idata=%0h dvld=%b exp ivld=1 idata=20082000 dvld=0",
                     i_rsp_valid, i_rdata, d_rsp_valid);
        end
    endtask

    // ----------------------------------------------------------- store/load
    task automatic test_store_load;
        int wren_cycles;
        int rsp_cycles;
        nxt;
        d_req = 1'b1; d_we = 1'b1; d_addr = 30'd2048; d_wdata = 32'hDEAD_BEEF;
        mid;
        n_checks++;
        if (d_gnt !== 1'b1 || i_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL store_gnt got d_gnt=%b i_gnt=%b exp d_gnt=1 i_gnt=0", d_gnt, i_gnt);
        end
        wren_cycles = 0;
        rsp_cycles  = 0;
        for (int c = 0; c < 2; c++) begin
            nxt;
            d_req = 1'b0;
            mid;
            if (mem_wren === 1'b1) wren_cycles++;
            if (d_rsp_valid === 1'b1) rsp_cycles++;
        end
        n_checks++;
        if (wren_cycles != 1 || rsp_cycles != 1) begin
            n_fail++;
            $display("FAIL store_pulse got wren_cycles=%0d rsp_cycles=%0d exp 1 1",
                     wren_cycles, rsp_cycles);
        end
        nxt;
        d_req = 1'b1; d_we = 1'b0; d_wdata = '0;
        mid;
        n_checks++;
        if (d_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL load_gnt got=%b exp=1", d_gnt);
        end
        nxt;
        d_req = 1'b0;
        mid;
        n_checks++;
        if ({mem_en, mem_rren, mem_wren} !== 3'b110 || mem_addr !== 30'd2048) begin
            n_fail++;
            $display("FAIL load_access got en/rren/wren=%b addr=%0d exp 110 addr=2048",
                     {mem_en, mem_rren, mem_wren}, mem_addr);
        end
        nxt;
        mid;
        n_checks++;
        if (d_rsp_valid !== 1'b1 || d_rdata !== 32'hDEAD_BEEF || i_rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL load_resp got dvld=%b ddata=%0h ivld=%b exp dvld=1 ddata=deadbeef ivld=0",
                     d_rsp_valid, d_rdata, i_rsp_valid);
        end
    endtask

    // ----------------------------------------------------- starvation/perf
    task automatic test_starvation;
        bit exp_i [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        bit got_i [10];
        int gcyc  [10];
        int ng;
        int stalls;
        nxt;
        rst = 1'b1;
        nxt;
        rst = 1'b0;
        i_req = 1'b1; i_addr = 30'd7;
        d_req = 1'b1; d_we = 1'b0; d_addr = 30'd5;
        ng = 0;
        stalls = 0;
        for (int c = 0; c < 40; c++) begin
            mid;
            if (i_req && !i_gnt) stalls++;
            if (i_gnt === 1'b1 || d_gnt === 1'b1) begin
                got_i[ng] = i_gnt;
                gcyc[ng]  = c;
                ng++;
            end
            if (ng == 10) break;
            nxt;
        end
        n_checks++;
        if (ng != 10) begin
            n_fail++;
            $display("FAIL starve_timeout got grants=%0d exp=10", ng);
        end
        for (int k = 0; k < ng; k++) begin
            n_checks++;
            if (got_i[k] != exp_i[k]) begin
                n_fail++;
                $display("FAIL starve_order idx=%0d got fetch=%0d exp fetch=%0d", k, got_i[k], exp_i[k]);
            end
        end
        for (int k = 1; k < ng; k++) begin
            n_checks++;
            if (gcyc[k] - gcyc[k-1] != 3) begin
                n_fail++;
                $display("FAIL starve_gap idx=%0d got=%0d exp=3", k, gcyc[k] - gcyc[k-1]);
            end
        end
        n_checks++;
        if (stalls != 26) begin
            n_fail++;
            $display("FAIL starve_stalls got=%0d exp=26", stalls);
        end
        nxt;
        i_req = 1'b0; d_req = 1'b0;
        nxt;
        nxt;
`ifdef MEM_ARB_PERF_EN
        mid;
        n_checks++;
        if (perf_d_grants !== 32'd8 || perf_i_grants !== 32'd2 || perf_i_stall !== 32'd26) begin
            n_fail++;
            $display("FAIL perf_counts got d=%0d i=%0d stall=%0d exp d=8 i=2 stall=26",
                     perf_d_grants, perf_i_grants, perf_i_stall);
        end
        nxt;
        rst = 1'b1;
        nxt;
        rst = 1'b0;
        mid;
        n_checks++;
        if (perf_d_grants !== 32'd0 || perf_i_grants !== 32'd0 || perf_i_stall !== 32'd0) begin
            n_fail++;
            $display("FAIL perf_clear got d=%0d i=%0d stall=%0d exp 0 0 0",
                     perf_d_grants, perf_i_grants, perf_i_stall);
        end
`endif
    endtask

    // ------------------------------------------------------------ RD_LAT=3
    task automatic test_rd_lat3;
        nxt;
        l3_d_req = 1'b1; l3_d_we = 1'b0; l3_d_addr = 30'd9;
        mid;
        n_checks++;
        if (l3_d_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL lat3_gnt got=%b exp=1", l3_d_gnt);
        end
        for (int k = 1; k <= 5; k++) begin
            nxt;
            l3_d_req = 1'b0;
            mid;
            n_checks++;
            if (k == 1) begin
                if ({l3_mem_en, l3_mem_rren} !== 2'b11 || l3_mem_addr !== 30'd9 || l3_d_rsp_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL lat3_access got en/rren=%b addr=%0d vld=%b exp 11 addr=9 vld=0",
                             {l3_mem_en, l3_mem_rren}, l3_mem_addr, l3_d_rsp_valid);
                end
            end else if (k < 4) begin
                if ({l3_mem_en, l3_mem_rren, l3_mem_wren} !== 3'b000 || l3_mem_addr !== '0 ||
                    l3_mem_wdata !== '0 || l3_d_rsp_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL lat3_wait k=%0d got en/rren/wren=%b addr=%0h vld=%b exp 000 addr=0 vld=0",
                             k, {l3_mem_en, l3_mem_rren, l3_mem_wren}, l3_mem_addr, l3_d_rsp_valid);
                end
            end else if (k == 4) begin
                if (l3_d_rsp_valid !== 1'b1 || l3_d_rdata !== 32'hA5A5_0009 || l3_i_rsp_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL lat3_resp got vld=%b data=%0h ivld=%b exp vld=1 data=a5a50009 ivld=0",
                             l3_d_rsp_valid, l3_d_rdata, l3_i_rsp_valid);
                end
            end else begin
                if (l3_d_rsp_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL lat3_after got vld=%b exp=0", l3_d_rsp_valid);
                end
            end
        end
    endtask

    // --------------------------------------------------------- reset abort
    task automatic test_reset_abort;
        nxt;
        i_req = 1'b1; i_addr = 30'd3; d_req = 1'b0;
        mid;
        n_checks++;
        if (i_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_fetch_gnt got=%b exp=1", i_gnt);
        end
        nxt;
        i_req = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 30'd11;
        rst = 1'b1;
        mid;
        n_checks++;
        if ({i_gnt, d_gnt, i_rsp_valid, d_rsp_valid, mem_en, mem_wren, mem_rren} !== 7'b0 ||
            mem_addr !== '0) begin
            n_fail++;
            $display("FAIL abort_outputs got ctl=%b addr=%0h exp ctl=0000000 addr=0",
                     {i_gnt, d_gnt, i_rsp_valid, d_rsp_valid, mem_en, mem_wren, mem_rren}, mem_addr);
        end
        nxt;
        rst = 1'b0;
        mid;
        n_checks++;
        if (d_gnt !== 1'b1 || i_rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_regrant got d_gnt=%b ivld=%b exp d_gnt=1 ivld=0", d_gnt, i_rsp_valid);
        end
        nxt;
        d_req = 1'b0;
        mid;
        n_checks++;
        if (mem_en !== 1'b1 || mem_addr !== 30'd11) begin
            n_fail++;
            $display("FAIL abort_access got en=%b addr=%0d exp en=1 addr=11", mem_en, mem_addr);
        end
        nxt;
        mid;
        n_checks++;
        if (d_rsp_valid !== 1'b1 || i_rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_resp got dvld=%b ivld=%b exp dvld=1 ivld=0", d_rsp_valid, i_rsp_valid);
        end
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) begin
            mem[a]  = '0;
            mem3[a] = '0;
        end
        mem[0]  = 32'h2008_2000;
        mem3[9] = 32'hA5A5_0009;

        rst = 1'b1;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        l3_i_req = 1'b0; l3_i_addr = '0;
        l3_d_req = 1'b0; l3_d_we = 1'b0; l3_d_addr = '0; l3_d_wdata = '0;

        test_reset;
        test_fetch;
        test_store_load;
        test_starvation;
        test_rd_lat3;
        test_reset_abort;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
